// File: rtl/hdmi_tdms_encoder.sv
// Three-channel TMDS 8b/10b encoder with per-channel running disparity.
// Optional TMDS_OUT_REG_EN adds a third output register stage (latency 3 instead of 2).
module hdmi_tdms_encoder (
  input  logic        clk,
  input  logic        srst,
  input  logic        i_de,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [23:0] i_pix,
  output logic [29:0] o_tdms
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] f_ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  // Transition-minimising stage: q_m[8]=1 marks the XOR chain.
  function automatic logic [8:0] f_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = f_ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8]    = ~use_xnor;
    return qm;
  endfunction

  // DC-balancing stage: returns {cnt_next[4:0], q_out[9:0]}.
  function automatic logic [14:0] f_encode(input logic [8:0] qm, input logic signed [4:0] cnt);
    logic signed [5:0] bal6;
    logic signed [4:0] bal;
    logic signed [4:0] cnt_nxt;
    logic [9:0]        q;
    bal6 = $signed({1'b0, f_ones8(qm[7:0]), 1'b0}) - 6'sd8;
    bal  = bal6[4:0];
    if ((cnt == 5'sd0) || (bal == 5'sd0)) begin
      q       = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt_nxt = cnt + (qm[8] ? bal : -bal);
    end else if (((cnt > 5'sd0) && (bal > 5'sd0)) || ((cnt < 5'sd0) && (bal < 5'sd0))) begin
      q       = {1'b1, qm[8], ~qm[7:0]};
      cnt_nxt = cnt - bal + (qm[8] ? 5'sd2 : 5'sd0);
    end else begin
      q       = {1'b0, qm[8], qm[7:0]};
      cnt_nxt = cnt + bal - (qm[8] ? 5'sd0 : 5'sd2);
    end
    return {cnt_nxt, q};
  endfunction

  function automatic logic [9:0] f_ctrl(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'b00:   sym = CTRL_00;
      2'b01:   sym = CTRL_01;
      2'b10:   sym = CTRL_10;
      default: sym = CTRL_11;
    endcase
    return sym;
  endfunction

  logic [8:0]        r_qm_p1 [3];
  logic              r_de_p1;
  logic [1:0]        r_ctrl_p1;
  logic [29:0]       r_tdms_p2;
  logic signed [4:0] r_cnt_p2 [3];
  logic [14:0]       w_enc [3];

  // Stage 1: q_m per channel; only ch0 carries sync bits.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_de_p1   <= 1'b0;
      r_ctrl_p1 <= 2'b00;
    end else begin
      r_de_p1   <= i_de;
      r_ctrl_p1 <= {i_vsync, i_hsync};
    end
    for (int ch = 0; ch < 3; ch++) r_qm_p1[ch] <= f_qm(i_pix[ch*8 +: 8]);
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) w_enc[ch] = f_encode(r_qm_p1[ch], r_cnt_p2[ch]);
  end

  // Stage 2: output symbol and disparity update
  always_ff @(posedge clk) begin
    if (srst) begin
      r_tdms_p2 <= {3{CTRL_00}};
      for (int ch = 0; ch < 3; ch++) r_cnt_p2[ch] <= 5'sd0;
    end else if (r_de_p1) begin
      for (int ch = 0; ch < 3; ch++) begin
        r_tdms_p2[ch*10 +: 10] <= w_enc[ch][9:0];
        r_cnt_p2[ch]           <= $signed(w_enc[ch][14:10]);
      end
    end else begin
      r_tdms_p2 <= {CTRL_00, CTRL_00, f_ctrl(r_ctrl_p1)};
      for (int ch = 0; ch < 3; ch++) r_cnt_p2[ch] <= 5'sd0;
    end
  end

`ifdef TMDS_OUT_REG_EN
  logic [29:0] r_tdms_p3;

  // Stage 3: retiming register ahead of the serializers
  always_ff @(posedge clk) begin
    if (srst) r_tdms_p3 <= {3{CTRL_00}};
    else      r_tdms_p3 <= r_tdms_p2;
  end

  assign o_tdms = r_tdms_p3;
`else
  assign o_tdms = r_tdms_p2;
`endif

endmodule

// File: tb/tb_hdmi_tdms_encoder.sv
// Self-checking bench for hdmi_tdms_encoder against a symbol-level TMDS reference model.
module tb_hdmi_tdms_encoder;

`ifdef TMDS_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [9:0]  RST_SYM = 10'b1101010100;
  localparam logic [29:0] RST3    = {3{RST_SYM}};

  logic        clk;
  logic        srst;
  logic        i_de;
  logic        i_hsync;
  logic        i_vsync;
  logic [23:0] i_pix;
  logic [29:0] o_tdms;

  int n_checks = 0;
  int n_fail   = 0;

  logic [29:0] line_tdms [3];
  logic        line_de   [3];
  logic [23:0] line_pix  [3];
  int          m_cnt     [3];
  logic [29:0] exp_tdms;
  logic        exp_de;
  logic [23:0] exp_pix;

  hdmi_tdms_encoder dut (
    .clk     (clk),
    .srst    (srst),
    .i_de    (i_de),
    .i_hsync (i_hsync),
    .i_vsync (i_vsync),
    .i_pix   (i_pix),
    .o_tdms  (o_tdms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ref_ctrl(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Symbol choice from the encoding rules; running disparity tracked from the emitted word.
  function automatic logic [9:0] ref_enc(input logic [7:0] d, input int cin, output int cout);
    int n1, bal;
    logic xn;
    logic [8:0] qm;
    logic [9:0] q;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    bal = 2 * $countones(qm[7:0]) - 8;
    if (cin == 0 || bal == 0)
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
    else if ((cin > 0 && bal > 0) || (cin < 0 && bal < 0))
      q = {1'b1, qm[8], ~qm[7:0]};
    else
      q = {1'b0, qm[8], qm[7:0]};
    cout = cin + 2 * $countones(q) - 10;
    return q;
  endfunction

  function automatic logic [7:0] ref_dec(input logic [9:0] q);
    logic [7:0] w, d;
    w = q[9] ? ~q[7:0] : q[7:0];
    d[0] = w[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return d;
  endfunction

  // One clock: apply inputs, advance the model, return at the following negedge.
  task automatic drive(input logic rst, input logic de, input logic hs, input logic vs,
                       input logic [23:0] pix);
    logic [29:0] sym;
    int co;
    srst = rst; i_de = de; i_hsync = hs; i_vsync = vs; i_pix = pix;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        line_tdms[i] = RST3; line_de[i] = 1'b0; line_pix[i] = '0; m_cnt[i] = 0;
      end
    end else begin
      sym = '0;
      for (int ch = 0; ch < 3; ch++) begin
        if (de) begin
          sym[ch*10 +: 10] = ref_enc(pix[ch*8 +: 8], m_cnt[ch], co);
          m_cnt[ch] = co;
        end else begin
          sym[ch*10 +: 10] = ref_ctrl(ch == 0 ? {vs, hs} : 2'b00);
          m_cnt[ch] = 0;
        end
      end
      for (int i = 2; i > 0; i--) begin
        line_tdms[i] = line_tdms[i-1]; line_de[i] = line_de[i-1]; line_pix[i] = line_pix[i-1];
      end
      line_tdms[0] = sym; line_de[0] = de; line_pix[0] = pix;
    end
    @(negedge clk);
    exp_tdms = line_tdms[LAT-1];
    exp_de   = line_de[LAT-1];
    exp_pix  = line_pix[LAT-1];
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, $urandom);
      n_checks++;
      if (o_tdms !== RST3) begin
        n_fail++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", k, o_tdms, RST3);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
      n_checks++;
      if (o_tdms !== RST3) begin
        n_fail++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", k, o_tdms, RST3);
      end
    end
  endtask

  task automatic test_ctrl();
    logic [29:0] want;
    for (int ph = 0; ph < 2; ph++) begin
      want = {RST_SYM, RST_SYM, (ph == 0) ? 10'b0010101011 : 10'b1010101011};
      for (int k = 0; k < 4; k++) begin
        drive(1'b0, 1'b0, 1'b1, ph[0], $urandom);
        n_checks++;
        if (o_tdms !== exp_tdms) begin
          n_fail++; $display("FAIL ctrl_model ph=%0d got=%h exp=%h", ph, o_tdms, exp_tdms);
        end
        if (k >= LAT - 1) begin
          n_checks++;
          if (o_tdms !== want) begin
            n_fail++; $display("FAIL ctrl_symbol ph=%0d got=%h exp=%h", ph, o_tdms, want);
          end
        end
      end
    end
  endtask

  task automatic test_zero_pixels();
    logic [29:0] obs [6];
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, (k < 2), 1'b0, 1'b0, 24'h000000);
      obs[k] = o_tdms;
      n_checks++;
      if (o_tdms !== exp_tdms) begin
        n_fail++; $display("FAIL zero_model k=%0d got=%h exp=%h", k, o_tdms, exp_tdms);
      end
    end
    n_checks++;
    if (obs[LAT-1] !== {3{10'b0100000000}}) begin
      n_fail++; $display("FAIL zero_first got=%h exp=%h", obs[LAT-1], {3{10'b0100000000}});
    end
    n_checks++;
    if (obs[LAT] !== {3{10'b1111111111}}) begin
      n_fail++; $display("FAIL zero_second got=%h exp=%h", obs[LAT], {3{10'b1111111111}});
    end
  endtask

  task automatic test_ff_restart();
    logic [29:0] obs [10];
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, (k == 0 || k == 5), 1'b0, 1'b0, 24'hFFFFFF);
      obs[k] = o_tdms;
      n_checks++;
      if (o_tdms !== exp_tdms) begin
        n_fail++; $display("FAIL ff_model k=%0d got=%h exp=%h", k, o_tdms, exp_tdms);
      end
    end
    n_checks++;
    if (obs[LAT-1] !== {3{10'b1000000000}}) begin
      n_fail++; $display("FAIL ff_first got=%h exp=%h", obs[LAT-1], {3{10'b1000000000}});
    end
    n_checks++;
    if (obs[LAT+4] !== {3{10'b1000000000}}) begin
      n_fail++; $display("FAIL ff_restart got=%h exp=%h", obs[LAT+4], {3{10'b1000000000}});
    end
  endtask

  // Random lines: model compare, decode-back and bounded running disparity on every cycle.
  task automatic run_line(input int npix, input int rst_at, input string tag);
    int disp [3];
    logic hs, vs;
    for (int c = 0; c < 3; c++) disp[c] = 0;
    hs = 1'($urandom); vs = 1'($urandom);
    for (int k = 0; k < 24 + npix + 8; k++) begin
      if (k == 24 + rst_at) drive(1'b1, 1'b1, hs, vs, $urandom);
      else if (k >= 24 && k < 24 + npix) drive(1'b0, 1'b1, hs, vs, $urandom);
      else drive(1'b0, 1'b0, hs, vs, $urandom);
      if (k == 24 + rst_at) begin
        n_checks++;
        if (o_tdms !== RST3) begin
          n_fail++; $display("FAIL %s reset_sym got=%h exp=%h", tag, o_tdms, RST3);
        end
      end
      n_checks++;
      if (o_tdms !== exp_tdms) begin
        n_fail++; $display("FAIL %s symbol k=%0d got=%h exp=%h", tag, k, o_tdms, exp_tdms);
      end
      for (int c = 0; c < 3; c++) begin
        if (!exp_de) disp[c] = 0;
        else begin
          disp[c] += 2 * $countones(o_tdms[c*10 +: 10]) - 10;
          n_checks++;
          if (ref_dec(o_tdms[c*10 +: 10]) !== exp_pix[c*8 +: 8]) begin
            n_fail++; $display("FAIL %s decode k=%0d ch=%0d got=%h exp=%h", tag, k, c,
                               ref_dec(o_tdms[c*10 +: 10]), exp_pix[c*8 +: 8]);
          end
          n_checks++;
          if (disp[c] > 10 || disp[c] < -10) begin
            n_fail++; $display("FAIL %s disparity k=%0d ch=%0d got=%0d limit=10", tag, k, c, disp[c]);
          end
        end
      end
    end
  endtask

  task automatic test_random_lines();
    for (int l = 0; l < 3; l++) run_line(1280, -100, "random_line");
  endtask

  task automatic test_midline_reset();
    run_line(1280, 600, "midline_reset");
  endtask

  initial begin
    srst = 1'b1; i_de = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0; i_pix = '0;
    for (int i = 0; i < 3; i++) begin
      line_tdms[i] = RST3; line_de[i] = 1'b0; line_pix[i] = '0; m_cnt[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_ctrl();
    test_zero_pixels();
    test_ff_restart();
    test_random_lines();
    test_midline_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
